seq_restoring_divider: RTL and testbench

- Sequential unsigned divider: computes quotient and remainder of two WIDTH-bit operands by restoring division, one trial subtraction per clock.
- Inverse of the adder/subtractor chain: each iteration reuses the same add/sub-with-k cell, with k=1 forcing a subtract.
- Sits beside the combinational arithmetic blocks as the first multi-cycle arithmetic unit, driven by a start/done handshake.

---
 rtl/seq_restoring_divider_pkg.sv | 26 ++
 rtl/seq_restoring_divider_addsub_step.sv | 37 +++
 rtl/seq_restoring_divider.sv | 215 +++++++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider_pkg
//   Shared definitions for the sequential restoring divider.
//   - div_state_t   : controller states (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH : default operand width
//   - cnt_width()   : iteration counter width for a given operand width
//   - CNT_W         : counter width for the default operand width
// -----------------------------------------------------------------------------
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must be able to hold 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_restoring_divider_addsub_step.sv
// -----------------------------------------------------------------------------
// addsub_step
//   Combinational W-bit ripple-carry add/subtract cell.
//   Ports:
//     a         : first operand
//     b         : second operand
//     k         : 0 = a + b, 1 = a - b (b inverted, carry-in forced to 1)
//     result    : W-bit sum/difference
//     carry_out : carry out of the MSB (for subtract: 1 means a >= b unsigned)
// -----------------------------------------------------------------------------
module addsub_step
  import seq_restoring_divider_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         k,
  output logic [W-1:0] result,
  output logic         carry_out
);

  logic [W:0]   carry;
  logic [W-1:0] b_eff;

  // Subtraction is a + ~b + 1: k both inverts b and supplies the carry-in.
  assign b_eff    = b ^ {W{k}};
  assign carry[0] = k;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign result[i]    = a[i] ^ b_eff[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
  end

  assign carry_out = carry[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
//   Sequential restoring divider: one trial subtraction per clock, WIDTH
//   iterations per division, start/done handshake.
//   Optional feature macro: SEQ_RESTORING_DIVIDER_SIGNED_EN
//     defined   -> two's complement operands, truncating division, remainder
//                  carries the dividend's sign, overflow flags MIN / -1.
//     undefined -> unsigned only, overflow is constant 0.
//   Ports:
//     clk         : rising-edge clock
//     rst         : synchronous active-high reset
//     start       : request, accepted in IDLE or DONE
//     dividend    : numerator, captured on accepted start
//     divisor     : denominator, captured on accepted start
//     busy        : high from the accepting edge through the DONE cycle
//     done        : one-cycle pulse, results valid from this cycle on
//     quotient    : result, held until the next completion
//     remainder   : result, held until the next completion
//     div_by_zero : captured divisor was zero (set together with done)
//     overflow    : signed overflow (MIN / -1), 0 in the unsigned build
// -----------------------------------------------------------------------------
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_BITS = cnt_width(WIDTH);
  localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(WIDTH - 1);

  div_state_t          state;
  logic [WIDTH:0]      rem_r;
  logic [WIDTH-1:0]    quo_r;
  logic [WIDTH-1:0]    dvsr_r;
  logic [CNT_BITS-1:0] cnt;

  logic [WIDTH:0]      rem_shift;
  logic [WIDTH:0]      trial;
  logic                trial_cout;
  logic [WIDTH:0]      rem_next;
  logic [WIDTH-1:0]    quo_next;

  logic [WIDTH-1:0]    dvd_mag;
  logic [WIDTH-1:0]    dvs_mag;
  logic [WIDTH-1:0]    quo_final;
  logic [WIDTH-1:0]    rem_final;
  logic                ovf_pending;
  logic                accept;

  logic                unused_bits;

  assign accept = start && ((state == IDLE) || (state == DONE));

  // Trial subtraction of the shifted partial remainder against the divisor.
  addsub_step #(.W(WIDTH + 1)) u_trial (
    .a         (rem_shift),
    .b         ({1'b0, dvsr_r}),
    .k         (1'b1),
    .result    (trial),
    .carry_out (trial_cout)
  );

  // One restoring step: shift {R,Q} left, keep the difference only when it
  // did not go negative, and record that decision in the new quotient LSB.
  // R never exceeds the divisor, so its MSB is always zero before the shift.
  always_comb begin
    rem_shift = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
    rem_next  = rem_shift;
    quo_next  = {quo_r[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial;
      quo_next = {quo_r[WIDTH-2:0], 1'b1};
    end
  end

`ifdef SEQ_RESTORING_DIVIDER_SIGNED_EN
  logic             sign_q_r;
  logic             sign_r_r;
  logic [WIDTH:0]   neg_dvd;
  logic [WIDTH:0]   neg_dvs;
  logic [WIDTH:0]   neg_quo;
  logic [WIDTH:0]   neg_rem;
  logic [3:0]       neg_cout;
  logic             min_by_neg_one;

  // The same add/sub cell computes 0 - x for magnitude and sign fix-up.
  addsub_step #(.W(WIDTH + 1)) u_neg_dvd (
    .a ('0), .b ({1'b0, dividend}), .k (1'b1),
    .result (neg_dvd), .carry_out (neg_cout[0])
  );
  addsub_step #(.W(WIDTH + 1)) u_neg_dvs (
    .a ('0), .b ({1'b0, divisor}), .k (1'b1),
    .result (neg_dvs), .carry_out (neg_cout[1])
  );
  addsub_step #(.W(WIDTH + 1)) u_neg_quo (
    .a ('0), .b ({1'b0, quo_next}), .k (1'b1),
    .result (neg_quo), .carry_out (neg_cout[2])
  );
  addsub_step #(.W(WIDTH + 1)) u_neg_rem (
    .a ('0), .b ({1'b0, rem_next[WIDTH-1:0]}), .k (1'b1),
    .result (neg_rem), .carry_out (neg_cout[3])
  );

  assign min_by_neg_one = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

  // Magnitudes go into the unsigned datapath; MIN maps to 2^(WIDTH-1),
  // which the unsigned WIDTH-bit datapath represents exactly.
  always_comb begin
    dvd_mag   = dividend[WIDTH-1] ? neg_dvd[WIDTH-1:0] : dividend;
    dvs_mag   = divisor[WIDTH-1]  ? neg_dvs[WIDTH-1:0] : divisor;
    quo_final = sign_q_r ? neg_quo[WIDTH-1:0] : quo_next;
    rem_final = sign_r_r ? neg_rem[WIDTH-1:0] : rem_next[WIDTH-1:0];
  end

  // Result signs and the overflow case are decided once, at capture time.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q_r    <= 1'b0;
      sign_r_r    <= 1'b0;
      ovf_pending <= 1'b0;
    end else if (accept) begin
      sign_q_r    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sign_r_r    <= dividend[WIDTH-1];
      ovf_pending <= min_by_neg_one;
    end
  end

  assign unused_bits = ^{trial_cout, rem_r[WIDTH], neg_cout,
                         neg_dvd[WIDTH], neg_dvs[WIDTH], neg_quo[WIDTH], neg_rem[WIDTH]};
`else
  assign dvd_mag     = dividend;
  assign dvs_mag     = divisor;
  assign quo_final   = quo_next;
  assign rem_final   = rem_next[WIDTH-1:0];
  assign ovf_pending = 1'b0;
  assign unused_bits = ^{trial_cout, rem_r[WIDTH]};
`endif

  // Controller and result registers. Reset wins over everything, including
  // an in-flight division, which is simply dropped without a done pulse.
  // A zero divisor skips RUN: the fixed results are loaded at capture so
  // they are already valid when done rises on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem_r       <= '0;
      quo_r       <= '0;
      dvsr_r      <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rem_r       <= '0;
            quo_r       <= dvd_mag;
            dvsr_r      <= dvs_mag;
            cnt         <= '0;
            busy        <= 1'b1;
            overflow    <= 1'b0;
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              state <= RUN;
            end
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        RUN: begin
          rem_r <= rem_next;
          quo_r <= quo_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            quotient  <= quo_final;
            remainder <= rem_final;
            overflow  <= ovf_pending;
            done      <= 1'b1;
            state     <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_divider
//   Scoreboard bench for seq_restoring_divider (WIDTH = 4). Stimulus pushes
//   the expected result and completion cycle; a negedge monitor pops and
//   compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_seq_restoring_divider;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
    int           when;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  exp_t sb[$];
  int   cycle = 0;
  int   tests = 0;
  int   fails = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference: plain integer division from the arithmetic definition.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int when);
    exp_t e;
    int   qi;
    int   ri;
    e.when = when;
    e.ovf  = 1'b0;
    if (b == 0) begin
      e.q  = {W{1'b1}};
      e.r  = a;
      e.dz = 1'b1;
    end else begin
`ifdef SEQ_RESTORING_DIVIDER_SIGNED_EN
      int sa;
      int sbv;
      sa  = $signed(a);
      sbv = $signed(b);
      qi  = sa / sbv;
      ri  = sa % sbv;
      e.ovf = (sa == -(1 << (W - 1))) && (sbv == -1);
`else
      qi = int'(a) / int'(b);
      ri = int'(a) % int'(b);
`endif
      e.q  = qi[W-1:0];
      e.r  = ri[W-1:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge; start is sampled at the next posedge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    lat      = (b == 0) ? 1 : W + 1;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b, cycle + lat));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic waitDone();
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    if (!done) checkOutput("done_timeout", done, 1);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_done", done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("quotient", quotient, e.q);
        checkOutput("remainder", remainder, e.r);
        checkOutput("div_by_zero", div_by_zero, e.dz);
        checkOutput("overflow", overflow, e.ovf);
        checkOutput("done_cycle", cycle, e.when);
        checkOutput("busy_at_done", busy, 1);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_quotient", quotient, 0);
    checkOutput("reset_remainder", remainder, 0);
    checkOutput("reset_dz", div_by_zero, 0);
    checkOutput("reset_ovf", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // 13/3 with busy profile: high for W cycles of RUN plus the DONE cycle.
    applyStimulus(4'd13, 4'd3);
    for (int i = 0; i < W + 2; i++) begin
      checkOutput("busy_profile", busy, (i < W + 1) ? 1 : 0);
      @(negedge clk);
    end
    waitDrain();

    // Divide by zero, then a normal 15/1 which must clear the flag.
    @(negedge clk);
    applyStimulus(4'd9, 4'd0);
    waitDrain();
    @(negedge clk);
    applyStimulus(4'd15, 4'd1);
    waitDrain();

    // Back-to-back: second start issued in the DONE cycle of the first.
    @(negedge clk);
    applyStimulus(4'd0, 4'd7);
    waitDone();
    applyStimulus(4'd15, 4'd4);
    waitDrain();

    // start and operand changes during RUN must be ignored.
    @(negedge clk);
    applyStimulus(4'd11, 4'd5);
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd2;
    repeat (2) @(negedge clk);
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    waitDrain();

    // Reset on the third RUN cycle aborts without a done pulse.
    @(negedge clk);
    applyStimulus(4'd14, 4'd3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_quotient", quotient, 0);
    checkOutput("abort_remainder", remainder, 0);
    checkOutput("abort_dz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(4'd14, 4'd3);
    waitDrain();

`ifdef SEQ_RESTORING_DIVIDER_SIGNED_EN
    @(negedge clk);
    applyStimulus(4'b1001, 4'd2);
    waitDrain();
    @(negedge clk);
    applyStimulus(4'b1000, 4'b1111);
    waitDrain();
`endif

    // Exhaustive sweep of all operand pairs.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        applyStimulus(4'(a), 4'(b));
        waitDrain();
      end
    end

    // Random back-to-back burst, occasionally with a zero divisor.
    @(negedge clk);
    applyStimulus(4'($urandom), 4'($urandom_range(1, 15)));
    for (int n = 0; n < 80; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = 4'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
      waitDone();
      applyStimulus(ra, rb);
    end
    waitDrain();
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
